cnn_mac_pipe: RTL and testbench
===============================

# cnn_mac_pipe

Pipelined, parametrised signed multiply-accumulate unit for the CNN datapath: generalises the fixed 10s×14s combinational multiplier into a configurable-width multiplier with a registered product pipeline. It also adds a dot-product accumulator with round, shift and saturate output. It sits behind the conv/FC weight and activation fetch loops and returns one quantised result per vector, marked by `in_last`.

## Interface
- `A_W`, 10: signed width of `din0` (activation).
- `B_W`, 14: signed width of `din1` (weight).
- `ACC_W`, 32: accumulator width; must be ≥ `A_W+B_W`.
- `OUT_W`, 16: signed result width; must be ≤ `ACC_W-SHIFT`.
- `MUL_STAGES`, 2: product register stages, legal range 1..4.
- `SHIFT`, 8: arithmetic right shift applied to the final sum, legal range 0..`ACC_W-1`.

Ports:
- `ap_clk`, in, 1: clock, rising edge.
- `ap_rst_n`, in, 1: reset, asynchronous, active-low.
- `ce`, in, 1: clock enable; low freezes all state.
- `clr`, in, 1: synchronous abort; flushes the pipeline and accumulator.
- `in_valid`, in, 1: `din0`/`din1` carry a valid element.
- `in_last`, in, 1: final element of the current vector; qualified by `in_valid`.
- `din0`, in, `A_W`: signed operand a.
- `din1`, in, `B_W`: signed operand b.
- `dout`, out, `OUT_W`: rounded, shifted, saturated vector result.
- `dout_valid`, out, 1: one-cycle pulse per completed vector.
- `ovf`, out, 1: saturation occurred for the current `dout`; valid with `dout_valid`.

## Operation
- Product: p = signed a × signed b, full `A_W+B_W` bits. p travels through `MUL_STAGES` registers, each carrying its own valid and last bits.
- Accumulator FSM, two states:
  - EMPTY: a valid product loads acc = sext(p). Go to ACCUM, or stay in EMPTY if last.
  - ACCUM: acc = acc + p, modulo `ACC_W`. A product with last returns the FSM to EMPTY.
- Finalise on a last product, with s = (value already in acc, or 0 in EMPTY) + p:
  - Round half-up: add 2^(`SHIFT`-1) when `SHIFT`>0. Compute in `ACC_W+1` bits.
  - Arithmetic shift right by `SHIFT`.
  - Saturate to [-2^(`OUT_W`-1), 2^(`OUT_W`-1)-1]. `ovf`=1 if clipping occurred.
  - Register the result into `dout` and pulse `dout_valid`.
- Back-to-back vectors are allowed. An element with `in_valid` the cycle after a last element starts a fresh sum. No bubble is required.
- `dout` and `ovf` hold their value until the next finalise.
- `in_valid`=0: no pipeline advance of valid data. Bubbles are allowed anywhere inside a vector.
- `clr`=1 (acts regardless of `ce`):
  - all pipeline valid bits go to 0;
  - the FSM goes to EMPTY;
  - `dout_valid` is 0 next cycle;
  - `dout` and `ovf` hold.
- `ce`=0 and `clr`=0: every register holds, including `dout_valid`. A held pulse is re-observed, so consumers qualify it with `ce`.

## Timing
- Reset values: `dout`=0, `dout_valid`=0, `ovf`=0. All pipeline valid bits are 0 and the FSM is in EMPTY.
- Latency: an element with last accepted at edge t produces `dout_valid`=1 after edge t+`MUL_STAGES`+1, counted in `ce`-high cycles.
- Throughput: one element per `ce`-high cycle.
- Asserting `ap_rst_n` low mid-vector discards the partial sum immediately, with no output pulse.
- `clr` in the same cycle as a last element drops that vector. No `dout_valid` is produced for it.

## Structure
- Shared package `cnn_mac_pkg`:
  - FSM state enum (EMPTY, ACCUM);
  - `sat_rshift` function (round, shift, saturate, overflow flag);
  - parameter legality checks.
- One sub-module, `cnn_mac_mul_pipe`: the signed multiplier plus `MUL_STAGES` registers with valid/last sideband. It is DSP48-inferable, with the first register on the operand inputs.
- The top level holds the accumulator FSM and the output register.

## Test plan
All scenarios use default parameters.
- Single-element vector a=-512, b=8191, last → `dout`=-16382, `ovf`=0. `dout_valid` rises 3 cycles after the input.
- Four elements a=-512, b=-8192, last on the 4th → sum 16777216, `dout`=32767, `ovf`=1.
- Vector (100,256),(-50,256),last, followed with no gap by (1,256),last → `dout`=50 then `dout`=1, on consecutive result pulses.
- Rounding check: (1,128),last → 1; (1,127),last → 0; (-1,129),last → -1.
- Deassert `ce` for 5 cycles mid-vector (3,256),(2,256),last → `dout`=5 with latency extended by 5. Assert `clr` mid-vector → no pulse, and the next vector's result is unaffected.
- Pull `ap_rst_n` low asynchronously between elements → outputs go to 0 without a clock edge. A subsequent vector (7,256),last → `dout`=7.

Source files
------------

// File: rtl/cnn_mac_pkg.sv
// cnn_mac_pkg: shared FSM state type, round/shift/saturate helper and parameter checks for cnn_mac_pipe
package cnn_mac_pkg;
  typedef enum logic {EMPTY, ACCUM} state_t;
  typedef struct packed {
    logic signed [63:0] val;
    logic               ovf;
  } sat_t;
  // s arrives sign-extended to 65 bits, so the rounding add cannot wrap for any ACC_W <= 64
  function automatic sat_t sat_rshift(input logic signed [64:0] s, input int sh, input int ow);
    logic signed [64:0] r, hi, lo;
    sat_t o;
    r = (sh > 0) ? (s + (65'sd1 <<< (sh - 1))) >>> sh : s;
    hi = (65'sd1 <<< (ow - 1)) - 65'sd1;
    lo = -(65'sd1 <<< (ow - 1));
    o.ovf = (r > hi) || (r < lo);
    o.val = (r > hi) ? 64'(hi) : (r < lo) ? 64'(lo) : 64'(r);
    return o;
  endfunction
  function automatic bit params_ok(input int a_w, b_w, acc_w, out_w, ms, sh);
    return acc_w >= a_w + b_w && acc_w <= 64 && out_w >= 1 && out_w <= acc_w - sh &&
           ms >= 1 && ms <= 4 && sh >= 0 && sh < acc_w;
  endfunction
endpackage

// File: rtl/cnn_mac_mul_pipe.sv
// cnn_mac_mul_pipe: operand register, signed multiply, STAGES product registers with valid/last sideband
// ports: clk/rst_n/ce/clr control; in_valid/in_last/a/b in; p/p_valid/p_last out of the last stage
module cnn_mac_mul_pipe #(
  parameter int A_W    = 10,
  parameter int B_W    = 14,
  parameter int STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ce,
  input  logic                     clr,
  input  logic                     in_valid,
  input  logic                     in_last,
  input  logic signed [A_W-1:0]    a,
  input  logic signed [B_W-1:0]    b,
  output logic signed [A_W+B_W-1:0] p,
  output logic                     p_valid,
  output logic                     p_last
);
  localparam int P_W = A_W + B_W;
  logic signed [A_W-1:0] ar;
  logic signed [B_W-1:0] br;
  logic                  av, al;
  logic signed [P_W-1:0] pr [STAGES];
  logic [STAGES-1:0]     pv, pl;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar <= '0;
      br <= '0;
      av <= 1'b0;
      al <= 1'b0;
      pv <= '0;
      pl <= '0;
      for (int i = 0; i < STAGES; i++) pr[i] <= '0;
    end else if (clr) begin
      av <= 1'b0;
      pv <= '0;
    end else if (ce) begin
      ar <= a;
      br <= b;
      av <= in_valid;
      al <= in_valid & in_last;
      pr[0] <= P_W'(ar) * P_W'(br);
      pv[0] <= av;
      pl[0] <= al;
      for (int i = 1; i < STAGES; i++) begin
        pr[i] <= pr[i-1];
        pv[i] <= pv[i-1];
        pl[i] <= pl[i-1];
      end
    end
  end
  assign p       = pr[STAGES-1];
  assign p_valid = pv[STAGES-1];
  assign p_last  = pl[STAGES-1];
endmodule

// File: rtl/cnn_mac_pipe.sv
// cnn_mac_pipe: pipelined signed MAC with per-vector round/shift/saturate result
// ports: ap_clk/ap_rst_n (async low), ce, clr; in_valid/in_last/din0/din1 in; dout/dout_valid/ovf out
module cnn_mac_pipe
  import cnn_mac_pkg::*;
#(
  parameter int A_W        = 10,
  parameter int B_W        = 14,
  parameter int ACC_W      = 32,
  parameter int OUT_W      = 16,
  parameter int MUL_STAGES = 2,
  parameter int SHIFT      = 8
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    ce,
  input  logic                    clr,
  input  logic                    in_valid,
  input  logic                    in_last,
  input  logic signed [A_W-1:0]   din0,
  input  logic signed [B_W-1:0]   din1,
  output logic signed [OUT_W-1:0] dout,
  output logic                    dout_valid,
  output logic                    ovf
);
  if (!params_ok(A_W, B_W, ACC_W, OUT_W, MUL_STAGES, SHIFT)) begin : g_bad_params
    $error("cnn_mac_pipe: illegal parameter combination");
  end
  logic signed [A_W+B_W-1:0] p;
  logic                      p_valid, p_last;
  state_t                    st, st_n;
  logic signed [ACC_W-1:0]   acc, s;
  sat_t                      r;
  cnn_mac_mul_pipe #(.A_W(A_W), .B_W(B_W), .STAGES(MUL_STAGES)) u_mul (
    .clk(ap_clk), .rst_n(ap_rst_n), .ce(ce), .clr(clr),
    .in_valid(in_valid), .in_last(in_last), .a(din0), .b(din1),
    .p(p), .p_valid(p_valid), .p_last(p_last)
  );
  // s doubles as the next accumulator value and the pre-rounding sum of a finishing vector
  always_comb begin
    s = ((st == ACCUM) ? acc : '0) + ACC_W'(p);
    r = sat_rshift(65'(s), SHIFT, OUT_W);
    st_n = !p_valid ? st : p_last ? EMPTY : ACCUM;
  end
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      st <= EMPTY;
      acc <= '0;
      dout <= '0;
      dout_valid <= 1'b0;
      ovf <= 1'b0;
    end else if (clr) begin
      st <= EMPTY;
      dout_valid <= 1'b0;
    end else if (ce) begin
      st <= st_n;
      if (p_valid) acc <= s;
      dout_valid <= p_valid & p_last;
      if (p_valid & p_last) begin
        dout <= OUT_W'(r.val);
        ovf <= r.ovf;
      end
    end
  end
endmodule

// File: tb/tb_cnn_mac_pipe.sv
// tb_cnn_mac_pipe: directed self-checking bench for cnn_mac_pipe at default parameters
module tb_cnn_mac_pipe;
  logic               ap_clk, ap_rst_n, ce, clr, in_valid, in_last;
  logic signed [9:0]  din0;
  logic signed [13:0] din1;
  logic signed [15:0] dout;
  logic               dout_valid, ovf;
  int                 cmp = 0, fails = 0;
  cnn_mac_pipe dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce), .clr(clr),
    .in_valid(in_valid), .in_last(in_last), .din0(din0), .din1(din1),
    .dout(dout), .dout_valid(dout_valid), .ovf(ovf)
  );
  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;
  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    cmp++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic send(input int a, input int b, input logic last);
    in_valid = 1'b1;
    in_last = last;
    din0 = 10'(a);
    din1 = 14'(b);
    step();
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask
  task automatic wait_res(input string tag, input int ed, input logic eo, input int elat);
    int n = 0;
    do begin
      step();
      n++;
    end while (!dout_valid && n < 20);
    chk({tag, "_pulse"}, 64'(dout_valid), 64'(1));
    if (elat > 0) chk({tag, "_lat"}, n, elat);
    chk({tag, "_dout"}, dout, ed);
    chk({tag, "_ovf"}, 64'(ovf), 64'(eo));
  endtask
  initial begin
    ap_rst_n = 1'b0; ce = 1'b1; clr = 1'b0; in_valid = 1'b0; in_last = 1'b0; din0 = '0; din1 = '0;
    step();
    step();
    chk("rst_dout", dout, 0);
    chk("rst_valid", 64'(dout_valid), 0);
    chk("rst_ovf", 64'(ovf), 0);
    ap_rst_n = 1'b1;
    step();
    send(-512, 8191, 1'b1);
    wait_res("single", -16382, 1'b0, 3);
    step();
    chk("pulse_one_cycle", 64'(dout_valid), 0);
    repeat (3) send(-512, -8192, 1'b0);
    send(-512, -8192, 1'b1);
    wait_res("sat", 32767, 1'b1, 3);
    send(100, 256, 1'b0);
    send(-50, 256, 1'b1);
    send(1, 256, 1'b1);
    wait_res("b2b_first", 50, 1'b0, 2);
    wait_res("b2b_second", 1, 1'b0, 1);
    send(1, 128, 1'b1);
    wait_res("round_up", 1, 1'b0, 3);
    send(1, 127, 1'b1);
    wait_res("round_down", 0, 1'b0, 3);
    send(-1, 129, 1'b1);
    wait_res("round_neg", -1, 1'b0, 3);
    ce = 1'b0;
    step();
    chk("ce_holds_pulse", 64'(dout_valid), 1);
    ce = 1'b1;
    step();
    chk("pulse_drops", 64'(dout_valid), 0);
    send(3, 256, 1'b0);
    ce = 1'b0;
    repeat (5) step();
    ce = 1'b1;
    send(2, 256, 1'b1);
    ce = 1'b0;
    repeat (5) step();
    chk("ce_frozen_no_pulse", 64'(dout_valid), 0);
    ce = 1'b1;
    wait_res("ce_stall", 5, 1'b0, 3);
    send(5, 256, 1'b0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    send(9, 256, 1'b1);
    wait_res("after_clr", 9, 1'b0, 3);
    send(5, 256, 1'b0);
    clr = 1'b1;
    send(4, 256, 1'b1);
    clr = 1'b0;
    begin
      int seen = 0;
      repeat (6) begin
        step();
        if (dout_valid) seen++;
      end
      chk("clr_last_no_pulse", seen, 0);
    end
    chk("clr_dout_hold", dout, 9);
    send(6, 256, 1'b0);
    #2 ap_rst_n = 1'b0;
    #1;
    chk("async_rst_dout", dout, 0);
    chk("async_rst_valid", 64'(dout_valid), 0);
    step();
    ap_rst_n = 1'b1;
    step();
    send(7, 256, 1'b1);
    wait_res("post_rst", 7, 1'b0, 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
    $finish;
  end
endmodule
